// File: rtl/ctrl_seq_if.sv
// Control bus of the instruction sequencer: fetched words and ALU flags in,
// datapath/memory/LFSR controls out.
interface ctrl_seq_if #(
   parameter int DW  = 8,
   parameter int PCW = 9,
   parameter int AW  = 8
);
   logic [8:0]     Instruction;
   logic           InstrValid;
   logic           Start;
   logic [2:0]     AluFlags;

   logic           BranchEn;
   logic [PCW-1:0] BranchTarget;
   logic           MemAddrCtrl;
   logic           MemWrEn;
   logic           MemValueCtrl;
   logic [AW-1:0]  MemoryTarget;
   logic [3:0]     OPCode;
   logic           ShiftFill;
   logic [1:0]     ALUInput;
   logic [DW-1:0]  ImmediateOut;
   logic           AccLoadEn;
   logic           RegLoadEn;
   logic           AccClr;
   logic           RegClr;
   logic           LFSRSetState;
   logic           LFSRSetTapPtrn;
   logic           LFSRShift;
   logic           Ack;
   logic           Busy;
   logic [2:0]     CmpFlags;

   // Environment side: fetch unit, ALU and host
   modport master (
      output Instruction, InstrValid, Start, AluFlags,
      input  BranchEn, BranchTarget, MemAddrCtrl, MemWrEn, MemValueCtrl,
             MemoryTarget, OPCode, ShiftFill, ALUInput, ImmediateOut,
             AccLoadEn, RegLoadEn, AccClr, RegClr,
             LFSRSetState, LFSRSetTapPtrn, LFSRShift, Ack, Busy, CmpFlags
   );

   // Sequencer side
   modport slave (
      input  Instruction, InstrValid, Start, AluFlags,
      output BranchEn, BranchTarget, MemAddrCtrl, MemWrEn, MemValueCtrl,
             MemoryTarget, OPCode, ShiftFill, ALUInput, ImmediateOut,
             AccLoadEn, RegLoadEn, AccClr, RegClr,
             LFSRSetState, LFSRSetTapPtrn, LFSRShift, Ack, Busy, CmpFlags
   );
endinterface

// File: rtl/ctrl_seq.sv
// Instruction sequencer: decodes 9-bit words into datapath controls, handling
// branch targets, skipped words, direct-address operands and multi-word immediates.
module ctrl_seq #(
   parameter int DW  = 8,
   parameter int PCW = 9,
   parameter int AW  = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   ctrl_seq_if.slave  bus
);
   localparam int IMW = (DW + 7) / 8;
   localparam int ICW = $clog2(IMW + 1);
   localparam logic [ICW-1:0] IMM_LAST = ICW'(IMW - 1);

   localparam logic [8:0] INSTR_STR_DIRECT = 9'b0_0000_1100;

   typedef enum logic [2:0] {
      REGULAR = 3'd0,
      TARGET  = 3'd1,
      SKIP    = 3'd2,
      IMM     = 3'd3,
      HALT    = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [8:0]     prev_q, prev_d;
   logic [DW-1:0]  imm_acc_q, imm_acc_d;
   logic [ICW-1:0] imm_cnt_q, imm_cnt_d;
   logic [2:0]     cmp_q, cmp_d;

   logic [8:0]     instr;
   logic [DW-1:0]  imm_next;

   logic           branch_en;
   logic [PCW-1:0] branch_target;
   logic           mem_addr_ctrl;
   logic           mem_wr_en;
   logic           mem_value_ctrl;
   logic [AW-1:0]  memory_target;
   logic [3:0]     opcode;
   logic           shift_fill;
   logic [1:0]     alu_input;
   logic [DW-1:0]  immediate_out;
   logic           acc_load_en;
   logic           reg_load_en;
   logic           acc_clr;
   logic           reg_clr;
   logic           lfsr_set_state;
   logic           lfsr_set_tap;
   logic           lfsr_shift;
   logic           ack;

   // Flags are {Zero, Eq, Gt}
   function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
      logic taken;
      case (cond)
         3'b000:  taken = 1'b1;
         3'b001:  taken = flags[2];
         3'b010:  taken = flags[0];
         3'b011:  taken = flags[0] | flags[1];
         3'b100:  taken = ~flags[0] & ~flags[1];
         3'b101:  taken = ~flags[0];
         3'b110:  taken = flags[1];
         default: taken = ~flags[1];
      endcase
      return taken;
   endfunction

   // ADM writes the register; every other math op writes the accumulator. Returns {acc, reg}.
   function automatic logic [1:0] load_sel(input logic [3:0] op);
      return (op == 4'b0011) ? 2'b01 : 2'b10;
   endfunction

   assign instr    = bus.Instruction;
   assign imm_next = (imm_acc_q << 8) | DW'(instr[7:0]);

   always_comb begin
      state_d        = state_q;
      prev_d         = prev_q;
      imm_acc_d      = imm_acc_q;
      imm_cnt_d      = imm_cnt_q;
      cmp_d          = cmp_q;
      branch_en      = 1'b0;
      branch_target  = '0;
      mem_addr_ctrl  = 1'b0;
      mem_wr_en      = 1'b0;
      mem_value_ctrl = 1'b0;
      memory_target  = '0;
      opcode         = 4'b0000;
      shift_fill     = 1'b0;
      alu_input      = 2'b00;
      immediate_out  = '0;
      acc_load_en    = 1'b0;
      reg_load_en    = 1'b0;
      acc_clr        = 1'b0;
      reg_clr        = 1'b0;
      lfsr_set_state = 1'b0;
      lfsr_set_tap   = 1'b0;
      lfsr_shift     = 1'b0;
      ack            = 1'b0;

      if (!Reset) begin
         case (state_q)
            REGULAR: begin
               if (bus.InstrValid) begin
                  if (instr[8]) begin
                     state_d = cond_true(instr[6:4], cmp_q) ? TARGET : SKIP;
                  end else if (instr[7:4] == 4'b0000) begin
                     case (instr[3:0])
                        4'b0001: acc_clr        = 1'b1;
                        4'b0010: reg_clr        = 1'b1;
                        4'b0011: lfsr_set_state = 1'b1;
                        4'b0100: lfsr_set_tap   = 1'b1;
                        4'b0101: lfsr_shift     = 1'b1;
                        4'b1000: cmp_d          = bus.AluFlags;
                        4'b1100: state_d        = TARGET;
                        4'b1110: begin
                           mem_addr_ctrl  = 1'b0;
                           mem_value_ctrl = 1'b1;
                           mem_wr_en      = 1'b1;
                        end
                        4'b1111: state_d        = HALT;
                        default: ;
                     endcase
                  end else if (instr[7:4] <= 4'b1001) begin
                     case (instr[3:2])
                        2'b00: begin
                           opcode                     = instr[7:4];
                           shift_fill                 = instr[1];
                           {acc_load_en, reg_load_en} = load_sel(instr[7:4]);
                        end
                        2'b01: state_d = TARGET;
                        2'b10: begin
                           state_d   = IMM;
                           imm_cnt_d = '0;
                           imm_acc_d = '0;
                        end
                        default: ;
                     endcase
                  end
                  // The follow-up states decode their word against the opcode that led there
                  if (state_d != REGULAR) begin
                     prev_d = instr;
                  end
               end
            end

            TARGET: begin
               if (bus.InstrValid) begin
                  state_d = REGULAR;
                  if (prev_q[8]) begin
                     branch_en     = 1'b1;
                     branch_target = instr[PCW-1:0];
                  end else if (prev_q == INSTR_STR_DIRECT) begin
                     memory_target  = instr[AW-1:0];
                     mem_addr_ctrl  = 1'b1;
                     mem_value_ctrl = 1'b1;
                     mem_wr_en      = 1'b1;
                  end else begin
                     memory_target              = instr[AW-1:0];
                     mem_addr_ctrl              = 1'b1;
                     alu_input                  = 2'b01;
                     opcode                     = prev_q[7:4];
                     shift_fill                 = prev_q[1];
                     {acc_load_en, reg_load_en} = load_sel(prev_q[7:4]);
                  end
               end
            end

            SKIP: begin
               if (bus.InstrValid) begin
                  state_d = REGULAR;
               end
            end

            IMM: begin
               if (bus.InstrValid) begin
                  if (imm_cnt_q == IMM_LAST) begin
                     state_d                    = REGULAR;
                     immediate_out              = imm_next;
                     alu_input                  = 2'b10;
                     opcode                     = prev_q[7:4];
                     shift_fill                 = prev_q[1];
                     {acc_load_en, reg_load_en} = load_sel(prev_q[7:4]);
                  end else begin
                     imm_acc_d = imm_next;
                     imm_cnt_d = imm_cnt_q + 1'b1;
                  end
               end
            end

            HALT: begin
               ack = 1'b1;
               if (bus.Start) begin
                  state_d = REGULAR;
               end
            end

            default: state_d = REGULAR;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= REGULAR;
         prev_q    <= '0;
         imm_acc_q <= '0;
         imm_cnt_q <= '0;
         cmp_q     <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         imm_acc_q <= imm_acc_d;
         imm_cnt_q <= imm_cnt_d;
         cmp_q     <= cmp_d;
      end
   end

   assign bus.BranchEn       = branch_en;
   assign bus.BranchTarget   = branch_target;
   assign bus.MemAddrCtrl    = mem_addr_ctrl;
   assign bus.MemWrEn        = mem_wr_en;
   assign bus.MemValueCtrl   = mem_value_ctrl;
   assign bus.MemoryTarget   = memory_target;
   assign bus.OPCode         = opcode;
   assign bus.ShiftFill      = shift_fill;
   assign bus.ALUInput       = alu_input;
   assign bus.ImmediateOut   = immediate_out;
   assign bus.AccLoadEn      = acc_load_en;
   assign bus.RegLoadEn      = reg_load_en;
   assign bus.AccClr         = acc_clr;
   assign bus.RegClr         = reg_clr;
   assign bus.LFSRSetState   = lfsr_set_state;
   assign bus.LFSRSetTapPtrn = lfsr_set_tap;
   assign bus.LFSRShift      = lfsr_shift;
   assign bus.Ack            = ack;
   assign bus.Busy           = (state_q != REGULAR) && !Reset;
   assign bus.CmpFlags       = Reset ? 3'b000 : cmp_q;
endmodule
